// File: rtl/decode_fp_pkg.sv
// Shared constants, FSM encoding and helpers for the FP16-to-BCD readout decoder.
package decode_fp_pkg;

    localparam int EXP_W       = 5;
    localparam int MAN_W       = 10;
    localparam int BIAS        = 15;
    localparam int EXP_SPECIAL = 31;

    localparam logic [3:0] BCD_ERR = 4'hF;

    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_NORM  = 6'b000010,
        S_INT   = 6'b000100,
        S_FRAC  = 6'b001000,
        S_ROUND = 6'b010000,
        S_DONE  = 6'b100000
    } state_t;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/fp16_to_fixed.sv
// Combinational FP16 unpack: scales {hidden,mantissa} into a 16.FRAC_W fixed-point
// value and flags Inf/NaN and zero/subnormal operands.
module fp16_to_fixed
    import decode_fp_pkg::*;
#(
    parameter int FRAC_W = 16
) (
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [MAN_W:0]    mant,
    output logic [15:0]       int_part,
    output logic [FRAC_W-1:0] frac_part,
    output logic              special,
    output logic              zero
);
    localparam int FX_W      = 16 + FRAC_W;
    // Exponent at which the mantissa lands unshifted in the fixed-point register.
    localparam int SHIFT_OFS = BIAS + MAN_W - FRAC_W;

    logic [FX_W-1:0] mant_ext;
    logic [FX_W-1:0] fixed;

    always_comb begin
        mant_ext = FX_W'(mant);
        special  = (exp_in == EXP_W'(EXP_SPECIAL));
        zero     = (exp_in == '0);
        if (int'(exp_in) >= SHIFT_OFS)
            fixed = mant_ext << (int'(exp_in) - SHIFT_OFS);
        else
            fixed = mant_ext >> (SHIFT_OFS - int'(exp_in));
    end

    assign int_part  = fixed[FX_W-1 -: 16];
    assign frac_part = fixed[FRAC_W-1:0];

endmodule

// File: rtl/decode_fp_bcd.sv
// Digit-serial FP16 to signed BCD converter with Start/Done/Ack handshake.
// Optional round-to-nearest on the last fractional digit: define DECODE_FP_ROUND_EN.
module decode_fp_bcd
    import decode_fp_pkg::*;
#(
    parameter int INT_DIGITS  = 2,
    parameter int FRAC_DIGITS = 2,
    parameter int FRAC_W      = 16
) (
    input  logic                                    Clk,
    input  logic                                    Reset,
    input  logic                                    Start,
    input  logic                                    Ack,
    input  logic [15:0]                             Fp_in,
    output logic                                    Busy,
    output logic                                    Done,
    output logic                                    Err,
    output logic                                    Neg,
    output logic [4*(INT_DIGITS+FRAC_DIGITS)-1:0]   Digits
);
    localparam int ND      = INT_DIGITS + FRAC_DIGITS;
    localparam int IW      = $clog2(ND);
    localparam int CW      = 4;
    localparam int OVF_LIM = pow10(INT_DIGITS);

    state_t state, state_nx;

    logic                  sign_r;
    logic [EXP_W-1:0]      exp_r;
    logic [MAN_W:0]        mant_r;
    logic [15:0]           int_r;
    logic [FRAC_W-1:0]     frac_r;
    logic [CW-1:0]         cnt;
    logic [ND-1:0][3:0]    dig;

    logic [15:0]           int_part;
    logic [FRAC_W-1:0]     frac_part;
    logic                  special, zero, ovf;
    logic [15:0]           int_div;
    logic [3:0]            int_mod;
    logic [FRAC_W+3:0]     frac_x10;
    logic [IW-1:0]         int_idx, frac_idx;
    logic                  int_last, frac_last;

    fp16_to_fixed #(.FRAC_W(FRAC_W)) u_unpack (
        .exp_in    (exp_r),
        .mant      (mant_r),
        .int_part  (int_part),
        .frac_part (frac_part),
        .special   (special),
        .zero      (zero)
    );

    assign ovf       = (int'(int_part) >= OVF_LIM);
    assign int_div   = int_r / 16'd10;
    assign int_mod   = 4'(int_r % 16'd10);
    assign frac_x10  = (FRAC_W+4)'(frac_r) * (FRAC_W+4)'(10);
    // Integer digits fill upward from the lowest integer nibble; fraction digits fill downward.
    assign int_idx   = IW'(FRAC_DIGITS) + IW'(cnt);
    assign frac_idx  = IW'(FRAC_DIGITS - 1) - IW'(cnt);
    assign int_last  = (cnt == CW'(INT_DIGITS - 1));
    assign frac_last = (cnt == CW'(FRAC_DIGITS - 1));
    assign Digits    = dig;

`ifdef DECODE_FP_ROUND_EN
    logic [ND-1:0][3:0] dig_inc;
    logic               carry;

    always_comb begin
        dig_inc = dig;
        carry   = 1'b1;
        for (int i = 0; i < ND; i++) begin
            if (carry) begin
                if (dig[i] == 4'd9) dig_inc[i] = 4'd0;
                else begin
                    dig_inc[i] = dig[i] + 4'd1;
                    carry      = 1'b0;
                end
            end
        end
    end
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (Start) state_nx = S_NORM;
            S_NORM:  state_nx = (special || zero || ovf) ? S_DONE : S_INT;
            S_INT:   if (int_last) state_nx = S_FRAC;
            S_FRAC: begin
`ifdef DECODE_FP_ROUND_EN
                if (frac_last) state_nx = S_ROUND;
`else
                if (frac_last) state_nx = S_DONE;
`endif
            end
`ifdef DECODE_FP_ROUND_EN
            S_ROUND: state_nx = S_DONE;
`endif
            S_DONE:  if (Ack) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sign_r <= 1'b0;
            exp_r  <= '0;
            mant_r <= '0;
            int_r  <= '0;
            frac_r <= '0;
            cnt    <= '0;
            dig    <= '0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            Err    <= 1'b0;
            Neg    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (Start) begin
                    sign_r <= Fp_in[15];
                    exp_r  <= Fp_in[14:10];
                    mant_r <= {|Fp_in[14:10], Fp_in[9:0]};
                    dig    <= '0;
                    Err    <= 1'b0;
                    Neg    <= 1'b0;
                    cnt    <= '0;
                    Busy   <= 1'b1;
                end
                S_NORM: begin
                    if (special) begin
                        Err  <= 1'b1;
                        dig  <= {ND{BCD_ERR}};
                        Busy <= 1'b0;
                        Done <= 1'b1;
                    end else if (zero) begin
                        Busy <= 1'b0;
                        Done <= 1'b1;
                    end else begin
                        Neg    <= sign_r;
                        int_r  <= int_part;
                        frac_r <= frac_part;
                        cnt    <= '0;
                        if (ovf) begin
                            Err  <= 1'b1;
                            dig  <= {ND{BCD_ERR}};
                            Busy <= 1'b0;
                            Done <= 1'b1;
                        end
                    end
                end
                S_INT: begin
                    dig[int_idx] <= int_mod;
                    int_r        <= int_div;
                    cnt          <= int_last ? '0 : cnt + 1'b1;
                end
                S_FRAC: begin
                    dig[frac_idx] <= frac_x10[FRAC_W+3:FRAC_W];
                    frac_r        <= frac_x10[FRAC_W-1:0];
                    cnt           <= cnt + 1'b1;
`ifndef DECODE_FP_ROUND_EN
                    if (frac_last) begin
                        Busy <= 1'b0;
                        Done <= 1'b1;
                    end
`endif
                end
`ifdef DECODE_FP_ROUND_EN
                S_ROUND: begin
                    // Leftover fraction of at least one half rounds the last digit up.
                    if (frac_r[FRAC_W-1]) begin
                        if (carry) begin
                            Err <= 1'b1;
                            dig <= {ND{BCD_ERR}};
                        end else begin
                            dig <= dig_inc;
                        end
                    end
                    Busy <= 1'b0;
                    Done <= 1'b1;
                end
`endif
                S_DONE: if (Ack) Done <= 1'b0;
                default: begin
                    Busy <= 1'b0;
                    Done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decode_fp_bcd.sv
// Directed bench for decode_fp_bcd (INT_DIGITS=2, FRAC_DIGITS=2): values, latency, handshake, reset.
module tb_decode_fp_bcd;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Ack;
    logic [15:0] Fp_in;
    logic        Busy, Done, Err, Neg;
    logic [15:0] Digits;

    int passed = 0;
    int total  = 0;

`ifdef DECODE_FP_ROUND_EN
    localparam int LAT      = 7;
    localparam logic [15:0] D_2E66 = 16'h0010;
`else
    localparam int LAT      = 6;
    localparam logic [15:0] D_2E66 = 16'h0009;
`endif

    decode_fp_bcd #(.INT_DIGITS(2), .FRAC_DIGITS(2), .FRAC_W(16)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Start  (Start),
        .Ack    (Ack),
        .Fp_in  (Fp_in),
        .Busy   (Busy),
        .Done   (Done),
        .Err    (Err),
        .Neg    (Neg),
        .Digits (Digits)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Cycle count includes the edge that accepts Start.
    task automatic run(input string tag, input logic [15:0] fp, input int lat,
                       input logic [15:0] dg, input logic e, input logic n, input bit poke);
        int cycles;
        @(negedge Clk);
        Fp_in = fp;
        Start = 1'b1;
        @(posedge Clk);
        cycles = 1;
        #1 Start = 1'b0;
        while (Done !== 1'b1 && cycles < 40) begin
            if (poke && cycles == 2) begin
                Start = 1'b1;
                Fp_in = 16'h3C00;
            end
            @(posedge Clk);
            cycles++;
            #1 Start = 1'b0;
        end
        chk({tag, "_lat"},    cycles, lat);
        chk({tag, "_digits"}, Digits, dg);
        chk({tag, "_err"},    Err, e);
        chk({tag, "_neg"},    Neg, n);
        chk({tag, "_busy"},   Busy, 1'b0);
    endtask

    task automatic ack_done(input string tag);
        @(negedge Clk);
        Ack = 1'b1;
        @(posedge Clk);
        #1 Ack = 1'b0;
        chk({tag, "_ack"}, Done, 1'b0);
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        Ack   = 1'b0;
        Fp_in = 16'h0000;
        #12;
        chk("reset_outs", {Busy, Done, Err, Neg, Digits}, 20'h0);
        @(negedge Clk);
        Reset = 1'b0;

        run("p075", 16'h3A00, LAT, 16'h0075, 1'b0, 1'b0, 1'b0);
        ack_done("p075");
        run("p12_5_poke", 16'h4A40, LAT, 16'h1250, 1'b0, 1'b0, 1'b1);
        ack_done("p12_5");
        run("m3_25", 16'hC280, LAT, 16'h0325, 1'b0, 1'b1, 1'b0);
        ack_done("m3_25");
        run("p0_1", 16'h2E66, LAT, D_2E66, 1'b0, 1'b0, 1'b0);
        ack_done("p0_1");
        run("p99_75", 16'h563C, LAT, 16'h9975, 1'b0, 1'b0, 1'b0);
        ack_done("p99_75");
        run("p100", 16'h5640, 2, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        ack_done("p100");
        run("inf", 16'h7C00, 2, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        ack_done("inf");
        run("nan", 16'h7E00, 2, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        ack_done("nan");
        run("mzero", 16'h8000, 2, 16'h0000, 1'b0, 1'b0, 1'b0);
        ack_done("mzero");
        run("subn", 16'h0001, 2, 16'h0000, 1'b0, 1'b0, 1'b0);
        ack_done("subn");

        // Done must hold without Ack, and Start in DONE must be ignored.
        run("hold", 16'h4A40, LAT, 16'h1250, 1'b0, 1'b0, 1'b0);
        Fp_in = 16'h7C00;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            Start = (i == 3);
        end
        @(negedge Clk);
        Start = 1'b0;
        chk("hold_done",   Done, 1'b1);
        chk("hold_digits", Digits, 16'h1250);
        chk("hold_err",    Err, 1'b0);
        ack_done("hold");
        chk("post_ack_digits", Digits, 16'h1250);

        // Async reset while in the fraction phase.
        @(negedge Clk);
        Fp_in = 16'h3A00;
        Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        repeat (3) @(posedge Clk);
        #2;
        chk("mid_busy", Busy, 1'b1);
        Reset = 1'b1;
        #1;
        chk("mid_reset_outs", {Busy, Done, Err, Neg, Digits}, 20'h0);
        @(negedge Clk);
        Reset = 1'b0;
        run("p1_0", 16'h3C00, LAT, 16'h0100, 1'b0, 1'b0, 1'b0);
        ack_done("p1_0");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
